grey_decoder: RTL and testbench

- Receiver-side companion to the 6-bit Gray counter.
- Samples an asynchronous Gray-coded bus, synchronizes it and glitch-filters it.
- Decodes each accepted value to binary and classifies every accepted change as step up, step down, or an illegal multi-bit jump.
- Keeps a signed position accumulator and an error counter.
- Sits on the io_in/la_data_in side of the user project as a loopback checker for the Gray counter output.

---
 rtl/grey_pkg.sv | 16 +
 rtl/grey_decoder_sync_filter.sv | 38 +++
 rtl/grey_decoder.sv | 64 ++++++
 tb/tb_grey_decoder.sv | 118 +++++++++++
 4 files changed

// File: rtl/grey_pkg.sv
// grey_pkg: shared Gray-code width and conversion helpers for the Gray counter and decoder.
package grey_pkg;
  localparam int GREY_W = 6;
  function automatic logic [GREY_W-1:0] f_grey2bin(input logic [GREY_W-1:0] g);
    logic [GREY_W-1:0] b;
    b[GREY_W-1] = g[GREY_W-1];
    for (int i = GREY_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [GREY_W-1:0] f_bin2grey(input logic [GREY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic int f_hamming(input logic [GREY_W-1:0] a, input logic [GREY_W-1:0] b);
    return $countones(a ^ b);
  endfunction
endpackage

// File: rtl/grey_decoder_sync_filter.sv
// grey_sync_filter: two-flop synchronizer plus stability filter; flags when a new stable value is ready.
module grey_sync_filter #(
  parameter int WIDTH = 6,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             w_reset,
  input  logic [WIDTH-1:0] i_grey,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_cand,
  output logic             o_accept
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);
  logic [WIDTH-1:0] r_s1, r_s2, r_cand, r_acc;
  logic [CW-1:0]    r_cnt;
  // r_cnt parks at STABLE once reached; cand==acc after the accept stops a repeat
  assign o_accept = (r_cnt == STABLE) && (r_s2 == r_cand) && (r_cand != r_acc);
  assign o_acc    = r_acc;
  assign o_cand   = r_cand;
  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
    end else begin
      r_s1 <= i_grey;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt < STABLE) r_cnt <= r_cnt + 1'b1;
      if (o_accept) r_acc <= r_cand;
    end
  end
endmodule

// File: rtl/grey_decoder.sv
// grey_decoder: filters a Gray bus, decodes it, classifies each change and tracks position and errors.
module grey_decoder
  import grey_pkg::*;
#(
  parameter int WIDTH = GREY_W,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             w_reset,
  input  logic [WIDTH-1:0] i_grey,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_valid,
  output logic             o_dir_up,
  output logic             o_step_err,
  output logic [CNT_W-1:0] o_pos,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_sticky_err
);
  logic [WIDTH-1:0] w_acc, w_cand, w_new_bin, w_old_bin, w_inc;
  logic             w_accept, w_legal, w_up, w_bad;
  grey_sync_filter #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk      (clk),
    .w_reset  (w_reset),
    .i_grey   (i_grey),
    .o_acc    (w_acc),
    .o_cand   (w_cand),
    .o_accept (w_accept)
  );
  assign w_new_bin = f_grey2bin(w_cand);
  assign w_old_bin = f_grey2bin(w_acc);
  assign w_inc     = w_old_bin + 1'b1;
  assign w_legal   = f_hamming(w_acc, w_cand) == 1;
  assign w_up      = w_new_bin == w_inc;
  assign w_bad     = w_accept && !w_legal;
  always_ff @(posedge clk) begin
    if (w_reset) begin
      o_bin        <= '0;
      o_valid      <= 1'b0;
      o_dir_up     <= 1'b0;
      o_step_err   <= 1'b0;
      o_pos        <= '0;
      o_err_cnt    <= '0;
      o_sticky_err <= 1'b0;
    end else begin
      o_valid    <= w_accept;
      o_step_err <= w_bad;
      if (w_accept) o_bin <= w_new_bin;
      if (w_accept && w_legal) begin
        o_pos    <= w_up ? o_pos + 1'b1 : o_pos - 1'b1;
        o_dir_up <= w_up;
      end
      // a fresh error outranks a simultaneous clear
      if (w_bad) begin
        o_err_cnt    <= i_clr_err ? CNT_W'(1) : (&o_err_cnt ? o_err_cnt : o_err_cnt + 1'b1);
        o_sticky_err <= 1'b1;
      end else if (i_clr_err) begin
        o_err_cnt    <= '0;
        o_sticky_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_grey_decoder.sv
// tb_grey_decoder: directed-vector bench for the Gray loopback decoder.
module tb_grey_decoder;
  logic        clk = 1'b0;
  logic        w_reset, i_clr_err;
  logic [5:0]  i_grey;
  logic [5:0]  o_bin;
  logic        o_valid, o_dir_up, o_step_err, o_sticky_err;
  logic [15:0] o_pos, o_err_cnt;
  int n_vec = 0, n_bad = 0;
  int pulses, first_at, errs, err_at;

  grey_decoder dut (
    .clk(clk), .w_reset(w_reset), .i_grey(i_grey), .i_clr_err(i_clr_err),
    .o_bin(o_bin), .o_valid(o_valid), .o_dir_up(o_dir_up), .o_step_err(o_step_err),
    .o_pos(o_pos), .o_err_cnt(o_err_cnt), .o_sticky_err(o_sticky_err)
  );

  always #5 clk = ~clk;

  // drive g at a falling edge, then watch n falling edges (k=1 follows E0)
  task automatic hold(input logic [5:0] g, input int n);
    pulses = 0; first_at = 0; errs = 0; err_at = 0;
    i_grey = g;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (o_valid) begin pulses++; if (first_at == 0) first_at = k; end
      if (o_step_err) begin errs++; if (err_at == 0) err_at = k; end
    end
  endtask

  task automatic test_reset;
    w_reset = 1'b1; i_clr_err = 1'b0; i_grey = 6'd0;
    repeat (3) @(negedge clk);
    w_reset = 1'b0;
    n_vec++; if ({o_bin, o_valid, o_dir_up, o_step_err, o_sticky_err} !== 10'd0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", {o_bin, o_valid, o_dir_up, o_step_err, o_sticky_err}); end
    n_vec++; if ({o_pos, o_err_cnt} !== 32'd0) begin n_bad++; $display("FAIL reset_cnts: got %h want 0", {o_pos, o_err_cnt}); end
    hold(6'b000000, 50);
    n_vec++; if (pulses !== 0) begin n_bad++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    n_vec++; if ({o_bin, o_pos, o_err_cnt} !== 38'd0) begin n_bad++; $display("FAIL idle_state: got %h want 0", {o_bin, o_pos, o_err_cnt}); end
  endtask

  task automatic test_count_up;
    hold(6'b000001, 10);
    n_vec++; if (pulses !== 1 || first_at !== 7) begin n_bad++; $display("FAIL up1_timing: got %0d pulses at %0d want 1 at 7", pulses, first_at); end
    n_vec++; if (o_bin !== 6'd1 || o_dir_up !== 1'b1) begin n_bad++; $display("FAIL up1_bin: got %0d/%b want 1/1", o_bin, o_dir_up); end
    hold(6'b000011, 10);
    n_vec++; if (pulses !== 1 || first_at !== 7 || o_bin !== 6'd2) begin n_bad++; $display("FAIL up2: got %0d pulses at %0d bin %0d want 1 at 7 bin 2", pulses, first_at, o_bin); end
    hold(6'b000010, 10);
    n_vec++; if (pulses !== 1 || first_at !== 7 || o_bin !== 6'd3) begin n_bad++; $display("FAIL up3: got %0d pulses at %0d bin %0d want 1 at 7 bin 3", pulses, first_at, o_bin); end
    n_vec++; if (o_pos !== 16'd3 || o_dir_up !== 1'b1 || o_err_cnt !== 16'd0) begin n_bad++; $display("FAIL up_pos: got pos %0d dir %b err %0d want 3 1 0", o_pos, o_dir_up, o_err_cnt); end
  endtask

  task automatic test_wrap;
    hold(6'b000011, 10);
    n_vec++; if (o_bin !== 6'd2 || o_pos !== 16'd2 || o_dir_up !== 1'b0) begin n_bad++; $display("FAIL down1: got bin %0d pos %0d dir %b want 2 2 0", o_bin, o_pos, o_dir_up); end
    hold(6'b000001, 10);
    hold(6'b000000, 10);
    n_vec++; if (o_bin !== 6'd0 || o_pos !== 16'd0) begin n_bad++; $display("FAIL down_zero: got bin %0d pos %0d want 0 0", o_bin, o_pos); end
    hold(6'b100000, 10);
    n_vec++; if (o_bin !== 6'd63 || o_pos !== 16'hFFFF || o_dir_up !== 1'b0) begin n_bad++; $display("FAIL wrap_down: got bin %0d pos %h dir %b want 63 ffff 0", o_bin, o_pos, o_dir_up); end
    hold(6'b000000, 10);
    n_vec++; if (o_bin !== 6'd0 || o_pos !== 16'd0 || o_dir_up !== 1'b1) begin n_bad++; $display("FAIL wrap_up: got bin %0d pos %h dir %b want 0 0 1", o_bin, o_pos, o_dir_up); end
  endtask

  task automatic test_glitch;
    int p;
    hold(6'b000001, 4);
    p = pulses;
    hold(6'b000000, 10);
    n_vec++; if (p + pulses !== 0 || o_bin !== 6'd0) begin n_bad++; $display("FAIL glitch4: got %0d pulses bin %0d want 0 0", p + pulses, o_bin); end
    hold(6'b000001, 5);
    p = pulses;
    hold(6'b000000, 5);
    n_vec++; if (p + pulses !== 1 || o_bin !== 6'd1 || o_pos !== 16'd1) begin n_bad++; $display("FAIL glitch5: got %0d pulses bin %0d pos %0d want 1 1 1", p + pulses, o_bin, o_pos); end
    hold(6'b000000, 10);
    n_vec++; if (pulses !== 1 || o_bin !== 6'd0 || o_pos !== 16'd0) begin n_bad++; $display("FAIL glitch_ret: got %0d pulses bin %0d pos %0d want 1 0 0", pulses, o_bin, o_pos); end
  endtask

  task automatic test_illegal;
    hold(6'b000011, 10);
    n_vec++; if (pulses !== 1 || errs !== 1 || first_at !== err_at) begin n_bad++; $display("FAIL ill_pulse: got v%0d e%0d at %0d/%0d want 1 1 together", pulses, errs, first_at, err_at); end
    n_vec++; if (o_bin !== 6'd2 || o_pos !== 16'd0 || o_dir_up !== 1'b0) begin n_bad++; $display("FAIL ill_hold: got bin %0d pos %0d dir %b want 2 0 0", o_bin, o_pos, o_dir_up); end
    n_vec++; if (o_err_cnt !== 16'd1 || o_sticky_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %0d/%b want 1/1", o_err_cnt, o_sticky_err); end
    i_clr_err = 1'b1; @(negedge clk); i_clr_err = 1'b0;
    n_vec++; if (o_err_cnt !== 16'd0 || o_sticky_err !== 1'b0) begin n_bad++; $display("FAIL clr: got %0d/%b want 0/0", o_err_cnt, o_sticky_err); end
    hold(6'b000000, 10);
    n_vec++; if (o_err_cnt !== 16'd1 || errs !== 1 || o_bin !== 6'd0) begin n_bad++; $display("FAIL ill2: got err %0d pulses %0d bin %0d want 1 1 0", o_err_cnt, errs, o_bin); end
    i_grey = 6'b000101;
    repeat (6) @(negedge clk);
    i_clr_err = 1'b1; @(negedge clk); i_clr_err = 1'b0;
    n_vec++; if (o_step_err !== 1'b1 || o_bin !== 6'd6) begin n_bad++; $display("FAIL clr_race_pulse: got %b bin %0d want 1 6", o_step_err, o_bin); end
    n_vec++; if (o_err_cnt !== 16'd1 || o_sticky_err !== 1'b1) begin n_bad++; $display("FAIL clr_race: got %0d/%b want 1/1", o_err_cnt, o_sticky_err); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    hold(6'b000001, 4);
    w_reset = 1'b1;
    @(negedge clk);
    w_reset = 1'b0;
    hold(6'b000000, 10);
    n_vec++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_pulse: got %0d want 0", pulses); end
    n_vec++; if ({o_bin, o_dir_up, o_sticky_err, o_pos, o_err_cnt} !== 40'd0) begin n_bad++; $display("FAIL rst_mid_state: got %h want 0", {o_bin, o_dir_up, o_sticky_err, o_pos, o_err_cnt}); end
    hold(6'b000001, 10);
    n_vec++; if (pulses !== 1 || first_at !== 7 || o_pos !== 16'd1 || o_bin !== 6'd1) begin n_bad++; $display("FAIL rst_mid_reacc: got %0d at %0d pos %0d bin %0d want 1 7 1 1", pulses, first_at, o_pos, o_bin); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_wrap;
    test_glitch;
    test_illegal;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
